// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encoding and frame geometry for the UART frame sequencer
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_PROC, RD, LAT, WR} state_t;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;
  localparam int DEF_IMG_SIZE = 76800;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_TIMEOUT = 50000000;
  localparam int DEF_TO_W = 26;
endpackage

// File: rtl/rx_timeout.sv
// rx_timeout: saturating idle-cycle watchdog with clear/enable and expiry flag
module rx_timeout import uart_frame_pkg::*; #(
  parameter int TO_W = DEF_TO_W,
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] count;
  assign expired = count == TO_W'(LIMIT);
  // count enabled idle cycles, holding at the limit until cleared
  always_ff @(posedge clk)
    if (!rst_n || clr) count <= '0;
    else if (en && !expired) count <= count + 1'b1;
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: sync-triggered frame load, Sobel hand-off and result streaming over UART
module uart_frame_ctrl import uart_frame_pkg::*; #(
  parameter int IMG_SIZE = DEF_IMG_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rd_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        wr_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic              proc_start,
  input  logic              proc_done,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_SIZE - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, idx;
  logic [7:0] hold;
  logic expired, load_hit, push;
  rx_timeout #(.TO_W(TO_W), .LIMIT(TIMEOUT)) u_to (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != LOAD || rx_done),
    .en(state == LOAD),
    .expired(expired)
  );
  // an expired timeout wins over a byte arriving in the same cycle
  assign load_hit = state == LOAD && rx_done && !expired;
  assign push = state == WR && !tx_full;
  assign wr_uart = push;
  assign wr_data = hold;
  assign res_addr = idx;
  assign err = state == LOAD && expired;
  assign busy = state != IDLE && !err;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = rx_done && rd_data == SYNC_BYTE ? LOAD : IDLE;
      LOAD:      nxt = expired ? IDLE : (load_hit && cnt == LAST ? START : LOAD);
      START:     nxt = WAIT_PROC;
      WAIT_PROC: nxt = proc_done ? RD : WAIT_PROC;
      RD:        nxt = LAT;
      LAT:       nxt = WR;
      WR:        nxt = push ? (idx == LAST ? IDLE : RD) : WR;
      default:   nxt = IDLE;
    endcase
  end
  // frame-buffer write port, start pulse, pixel/read indices and transmit holding byte
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      proc_start <= 1'b0;
      cnt <= '0;
      idx <= '0;
      hold <= '0;
    end else begin
      mem_we <= load_hit;
      if (load_hit) begin
        mem_addr <= cnt;
        mem_wdata <= rd_data;
      end
      proc_start <= state == START;
      cnt <= state == IDLE ? '0 : (load_hit && cnt != LAST ? cnt + 1'b1 : cnt);
      if (state == WAIT_PROC) idx <= '0;
      else if (push) idx <= idx == LAST ? '0 : idx + 1'b1;
      if (state == LAT) hold <= res_rdata;
    end
endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame-level sequencer sitting between the UART core (rx/tx FIFO wrapper) and the Sobel frame buffers. It waits for a sync byte on the UART receive stream, then writes exactly IMG_SIZE received pixel bytes into the input frame buffer. It then pulses the edge-detection engine, waits for completion, and streams IMG_SIZE result bytes back out through the UART transmit FIFO, honouring `tx_full`. A receive timeout aborts partial frames so the host can resynchronise.

## Interface
- `IMG_SIZE`, 76800: pixels per frame (320x240).
- `ADDR_W`, 17: frame-buffer address width; must satisfy 2^ADDR_W >= IMG_SIZE.
- `SYNC_BYTE`, 8'h55: byte that opens a frame in IDLE.
- `TIMEOUT`, 50000000: idle cycles allowed between bytes in LOAD before abort.
- `TO_W`, 26: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_done`  in  1  one-cycle pulse from UART: `rd_data` valid this cycle.
- `rd_data`  in  8  received byte.
- `tx_full`  in  1  UART tx FIFO full.
- `wr_uart`  out  1  one-cycle push into tx FIFO.
- `wr_data`  out  8  byte pushed with `wr_uart`.
- `mem_we`  out  1  input frame-buffer write enable.
- `mem_addr`  out  ADDR_W  input frame-buffer write address.
- `mem_wdata`  out  8  input frame-buffer write data.
- `res_addr`  out  ADDR_W  result-buffer read address (synchronous RAM, 1-cycle read latency).
- `res_rdata`  in  8  result-buffer read data.
- `proc_start`  out  1  one-cycle pulse to start the Sobel engine.
- `proc_done`  in  1  one-cycle pulse from the Sobel engine on completion.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on receive timeout.

## Operation
- States: IDLE, LOAD, START, WAIT_PROC, RD, LAT, WR.
- IDLE: a `rx_done` with `rd_data`==SYNC_BYTE goes to LOAD with pixel count 0 and timeout count 0. Any other byte is dropped.
- LOAD: each `rx_done` registers `mem_we`=1, `mem_addr`=count, `mem_wdata`=`rd_data` for the following cycle, increments count, and clears the timeout counter.
  - The byte written at address IMG_SIZE-1 moves the block to START.
  - The timeout counter increments every cycle without `rx_done`. When it reaches TIMEOUT, the block pulses `err` and returns to IDLE. Written data is left as is.
- START: `proc_start`=1 for exactly one cycle, then WAIT_PROC.
- WAIT_PROC: waits for `proc_done`, then goes to RD with the read index at 0. There is no timeout in this state.
- RD: drives `res_addr`=index, then goes to LAT.
- LAT: registers `res_rdata` into the holding byte, then goes to WR.
- WR: holds until `tx_full`==0, then pulses `wr_uart` with `wr_data`=holding byte and increments the index.
  - If the pushed byte was index IMG_SIZE-1, the next state is IDLE.
  - Otherwise the next state is RD.
- Counters are ADDR_W bits wide; the terminal compare is against IMG_SIZE-1, so counters never wrap.
- Ignored events:
  - `rx_done` in START, WAIT_PROC, RD, LAT and WR is ignored (host must not send).
  - `proc_done` outside WAIT_PROC is ignored.
  - A SYNC_BYTE arriving in LOAD is stored as pixel data.
- Reset mid-operation: returns to IDLE, clears all counters, and deasserts all outputs the next cycle. Pulses in flight are not completed.

## Timing
- Reset values: every output is 0, including `res_addr`, `mem_addr`, `wr_data` and `mem_wdata`. State is IDLE.
- Write latency: `rx_done` in cycle n gives `mem_we` in cycle n+1. `mem_we` is never high for two consecutive cycles unless `rx_done` was.
- Last pixel: `rx_done` in cycle n gives `mem_we` in n+1 and `proc_start` in n+2.
- Processing hand-off: `proc_done` in cycle n puts `res_addr` valid in n+1. Data is latched at n+2, and the earliest `wr_uart` is at n+3.
- Transmit throughput: the steady-state byte period is 3 cycles when `tx_full`==0. This is far faster than the UART line rate, so `tx_full` backpressure is the normal case.
- `wr_uart` is only asserted while `tx_full`==0 in the same cycle.
- `err` and `busy`: `err` is asserted in the cycle the counter equals TIMEOUT. `busy` falls in that same cycle.

## Structure
- Shared package/header `uart_frame_pkg` holds:
  - the state encoding constants;
  - SYNC_BYTE;
  - the default IMG_SIZE, ADDR_W and TIMEOUT values, so the top level and the Sobel engine agree on frame geometry.
- One natural sub-module: `rx_timeout`. It is a TO_W-bit counter with `clr`/`en` inputs and a `expired` output, reused for future command-link watchdogs.
- Everything else is a single FSM plus index/holding registers in `uart_frame_ctrl`.

## Test plan
Run with IMG_SIZE=4, ADDR_W=2, TIMEOUT=100.
- Sync and load: send bytes 0x12, 0x55, 0x0A, 0x0B, 0x0C, 0x0D.
  - 0x12 is dropped.
  - Four writes occur: addr 0..3 with data 0A, 0B, 0C, 0D.
  - `proc_start` pulses once, 1 cycle after the last write.
  - `busy` rises after 0x55.
- Readback: preload the result RAM with E0..E3 and pulse `proc_done`.
  - `wr_uart` pulses 4 times with `wr_data` E0, E1, E2, E3.
  - `busy` drops after E3 and the state is IDLE.
- Backpressure: hold `tx_full`=1 for 50 cycles during readback.
  - No `wr_uart` while full.
  - The byte order and count are unchanged.
- Timeout: send 0x55 and 2 pixels, then go silent.
  - `err` pulses exactly once, 100 cycles after the last `rx_done`.
  - The block returns to IDLE, and a fresh frame then loads from addr 0.
- Stray events:
  - `proc_done` pulsed in IDLE and LOAD produces no state change.
  - `rx_done` during WAIT_PROC causes no `mem_we`.
- Reset mid-readback: assert `rst_n`=0 after 2 bytes are sent.
  - All outputs are 0 the next cycle.
  - A new 0x55 frame proceeds normally.
